fifo_rd_packer: RTL and testbench
=================================

// Module: fifo_rd_packer
// PURPOSE
//  Read-side consumer of the dual-clock FIFO, running in the read clock domain (clk_b).
//  Drives ren_b from the FIFO's empty flag and captures dout_b one cycle after each read.
//  Packs PACK consecutive FIFO_WIDTH-bit words into one output beat.
//  Presents beats on a valid/ready stream, with m_last marking frame boundaries.
// PARAMETERS
//  FIFO_WIDTH   16  width of one FIFO word (matches the FIFO's FIFO_WIDTH)
//  PACK         2   words per output beat; legal values 2..8
//  FRAME_BEATS  64  beats per frame; m_last is set on beat FRAME_BEATS-1
// PORTS
//  clk_b    in   1               read-domain clock; all logic on posedge
//  rst      in   1               synchronous, active-high reset
//  empty    in   1               FIFO empty flag (combinational, clk_b domain)
//  ren_b    out  1               FIFO read enable
//  dout_b   in   FIFO_WIDTH      FIFO read data, valid the cycle after ren_b && !empty
//  flush    in   1               synchronous discard of all held and in-flight data
//  m_data   out  FIFO_WIDTH*PACK packed output beat
//  m_valid  out  1               beat available
//  m_ready  in   1               downstream accepts; transfer = m_valid && m_ready
//  m_last   out  1               final beat of a frame, qualified by m_valid
// BEHAVIOUR
//  Interface: one clock; reset is synchronous and active-high. Clock is clk_b, reset is rst.
//  Reset values: ren_b=0, m_valid=0, m_last=0, m_data=0.
//    Internal state cleared: occ=0, lane index=0, beat counter=0, queue empty, rd_pend=0.
//  Credit counter occ [$clog2(2*PACK+1)-1:0]:
//    counts words issued but not yet popped as part of a beat; capacity is 2*PACK.
//    ren_b = !rst && !flush && !empty && (occ < 2*PACK)   (combinational).
//    occ += 1 on ren_b; occ -= PACK on a transfer; both in one cycle apply the net change.
//  Read latency:
//    rd_pend <= ren_b. When rd_pend=1, dout_b is written into lane[idx] of the pack register.
//    Lane 0 occupies bits [FIFO_WIDTH-1:0] (first word read = least significant).
//    idx wraps PACK-1 -> 0. When the last lane fills, the full pack is pushed into a 2-entry beat queue.
//  Output:
//    m_valid = queue not empty; m_data/m_last come from the queue head.
//    m_data and m_last hold stable while m_valid && !m_ready. No combinational path from m_ready to m_valid.
//    Latency: for an idle block with data in the FIFO, first m_valid rises PACK+1 cycles after empty falls.
//    Sustained rate: 1 word/cycle in, 1 beat per PACK cycles out when m_ready=1.
//  Frame counter [$clog2(FRAME_BEATS)-1:0]:
//    counts pushed beats; the pushed beat is tagged last when the count = FRAME_BEATS-1, then the count wraps to 0.
//  Boundaries:
//    - occ = 2*PACK: ren_b=0 even if !empty. Credit is never exceeded, so no word is ever dropped.
//    - Queue full while the last lane fills: cannot occur by credit rule; an assertion checks this.
//    - empty rises mid-pack: the partial pack is held indefinitely; no partial beat is ever emitted.
//    - Simultaneous push and pop with queue holding 1 entry: occupancy stays 1; order is preserved.
//  flush (priority below rst, above all else):
//    - ren_b=0 that cycle.
//    - Queue, pack register, idx, frame counter and occ are cleared.
//    - A word returned in the cycle after flush (rd_pend from the prior cycle) is discarded.
//    - m_valid=0 from the next cycle.
//  rst mid-operation: same as flush, plus m_data<=0. The FIFO's own reset clears its side.
// STRUCTURE
//  Package fifo_pkg:
//    - FIFO_WIDTH default.
//    - function clog2.
//    - localparam CAP = 2*PACK.
//  Sub-module beat_skid_q: 2-entry valid/ready queue of {last, data}.
//    Ports: push, push_data, full, pop, head, empty; pop and push in the same cycle are allowed.
//  Top level holds the credit counter, rd_pend, pack register, lane index and frame counter.
// TESTING
//  1. Reset: hold rst 3 cycles, FIFO non-empty.
//     -> ren_b=0, m_valid=0, m_data=0 throughout; ren_b=1 the cycle after rst falls.
//  2. Pack order, PACK=2: FIFO words 0x1111, 0x2222, m_ready=1.
//     -> one beat m_data=0x2222_1111, m_valid high exactly 1 cycle, arriving 3 cycles after the first ren_b.
//  3. Backpressure: m_ready=0, 10 words in FIFO.
//     -> ren_b pulses exactly 4 times, occ=4, two beats queued, m_data stable.
//     -> Release m_ready: beats emitted in order with no loss.
//  4. Starve: 3 words then empty.
//     -> one beat out, third word held.
//     -> 4th word arrives 20 cycles later: second beat = {w4,w3}.
//  5. Frame: FRAME_BEATS=4, 16 words streamed.
//     -> m_last=1 on beats 3 and 7 only.
//  6. Flush with rd_pend=1 and 1 beat queued.
//     -> m_valid=0 next cycle; returned word discarded.
//     -> Next beat formed solely from post-flush reads; frame count restarts at 0.

Source files
------------

// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pkg
// Description : Shared constants and helpers for the FIFO read-side packer.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

  localparam int FIFO_WIDTH_DEF = 16;

  // Ceiling log2; returns 0 for inputs of 0 or 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Counter width that is never zero, even for single-state counters.
  function automatic int cnt_width(input int states);
    return (clog2(states) < 1) ? 1 : clog2(states);
  endfunction

  // Read credit: two full beats may be outstanding (one in the queue
  // head, one being filled or queued behind it).
  function automatic int credit_cap(input int pack);
    return 2 * pack;
  endfunction

endpackage
`default_nettype wire

// File: rtl/beat_skid_q.sv
`default_nettype none
// ============================================================================
// Module      : beat_skid_q
// Description : Two-entry valid/ready queue of {last, data} beats. Entry 0 is
//               always the head, so the output is a plain register.
// Revision    : 1.0 - initial release
// ============================================================================
module beat_skid_q #(
  parameter int WIDTH = 33
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty
);

  logic [WIDTH-1:0] ent0;
  logic [WIDTH-1:0] ent1;
  logic [1:0]       cnt;
  logic             do_pop;
  logic             do_push;

  assign empty   = (cnt == 2'd0);
  assign full    = (cnt == 2'd2);
  assign head    = ent0;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Shift-style storage: a pop moves entry 1 forward, a push fills the first free slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      ent0 <= '0;
      ent1 <= '0;
      cnt  <= 2'd0;
    end else if (clear) begin
      cnt <= 2'd0;
    end else if (do_push && do_pop) begin
      if (cnt == 2'd1) begin
        ent0 <= push_data;
      end else begin
        ent0 <= ent1;
        ent1 <= push_data;
      end
    end else if (do_push) begin
      if (cnt == 2'd0) ent0 <= push_data;
      else             ent1 <= push_data;
      cnt <= cnt + 2'd1;
    end else if (do_pop) begin
      if (cnt == 2'd2) ent0 <= ent1;
      cnt <= cnt - 2'd1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fifo_rd_packer.sv
`default_nettype none
// ============================================================================
// Module      : fifo_rd_packer
// Description : Read-side consumer of a dual-clock FIFO. Issues reads against
//               a credit budget, packs PACK words per beat (first word in the
//               least significant lane) and streams beats with frame marking.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_rd_packer
  import fifo_pkg::*;
#(
  parameter int FIFO_WIDTH  = FIFO_WIDTH_DEF,
  parameter int PACK        = 2,
  parameter int FRAME_BEATS = 64
) (
  input  logic                       clk_b,
  input  logic                       rst,
  input  logic                       empty,
  output logic                       ren_b,
  input  logic [FIFO_WIDTH-1:0]      dout_b,
  input  logic                       flush,
  output logic [FIFO_WIDTH*PACK-1:0] m_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic                       m_last
);

  localparam int CAP    = credit_cap(PACK);
  localparam int OCC_W  = clog2(CAP + 1);
  localparam int IDX_W  = cnt_width(PACK);
  localparam int FRM_W  = cnt_width(FRAME_BEATS);
  localparam int BEAT_W = FIFO_WIDTH * PACK;

  localparam logic [OCC_W-1:0] OCC_CAP   = OCC_W'(CAP);
  localparam logic [OCC_W-1:0] OCC_PACK  = OCC_W'(PACK);
  localparam logic [IDX_W-1:0] LAST_LANE = IDX_W'(PACK - 1);
  localparam logic [FRM_W-1:0] LAST_BEAT = FRM_W'(FRAME_BEATS - 1);

  logic [OCC_W-1:0]  occ;
  logic              rd_pend;
  logic [IDX_W-1:0]  idx;
  logic [FRM_W-1:0]  frm_cnt;
  logic [BEAT_W-1:0] pack_q;
  logic [BEAT_W-1:0] pack_next;
  logic              transfer;
  logic              push;
  logic              q_full;
  logic              q_empty;
  logic [BEAT_W:0]   q_head;

  // Read only with spare credit; reset and flush both suppress the read.
  assign ren_b    = !rst && !flush && !empty && (occ < OCC_CAP);
  assign transfer = m_valid && m_ready;
  assign push     = rd_pend && !flush && (idx == LAST_LANE);

  // Returned word merged into its lane; on the last lane this is the full beat.
  always_comb begin
    pack_next = pack_q;
    pack_next[int'(idx)*FIFO_WIDTH +: FIFO_WIDTH] = dout_b;
  end

  // Credit counter: words issued but not yet handed downstream inside a beat.
  always_ff @(posedge clk_b) begin
    if (rst || flush) begin
      occ <= '0;
    end else begin
      occ <= occ + {{(OCC_W-1){1'b0}}, ren_b} - (transfer ? OCC_PACK : '0);
    end
  end

  // Read-return tracker; a word in flight across a flush is dropped here.
  always_ff @(posedge clk_b) begin
    if (rst || flush) rd_pend <= 1'b0;
    else              rd_pend <= ren_b;
  end

  // Pack register and lane index; the partial pack waits for more words indefinitely.
  always_ff @(posedge clk_b) begin
    if (rst || flush) begin
      pack_q <= '0;
      idx    <= '0;
    end else if (rd_pend) begin
      pack_q <= pack_next;
      idx    <= (idx == LAST_LANE) ? '0 : idx + 1'b1;
    end
  end

  // Frame counter over pushed beats; the beat pushed at FRAME_BEATS-1 carries last.
  always_ff @(posedge clk_b) begin
    if (rst || flush) begin
      frm_cnt <= '0;
    end else if (push) begin
      frm_cnt <= (frm_cnt == LAST_BEAT) ? '0 : frm_cnt + 1'b1;
    end
  end

  beat_skid_q #(
    .WIDTH (BEAT_W + 1)
  ) u_beat_q (
    .clk       (clk_b),
    .rst       (rst),
    .clear     (flush),
    .push      (push),
    .push_data ({(frm_cnt == LAST_BEAT), pack_next}),
    .full      (q_full),
    .pop       (m_ready),
    .head      (q_head),
    .empty     (q_empty)
  );

  assign m_valid = !q_empty;
  assign m_last  = q_head[BEAT_W];
  assign m_data  = q_head[BEAT_W-1:0];

  // The credit budget must make a push into a full queue impossible.
  a_no_push_when_full : assert property (@(posedge clk_b) disable iff (rst) !(push && q_full));

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_packer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_fifo_rd_packer
// Description : Self-checking bench for fifo_rd_packer with a queue-based
//               FIFO model, a word-list reference model and a beat scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_rd_packer;

  localparam int W    = 16;
  localparam int PACK = 2;
  localparam int FB   = 4;
  localparam int BW   = W * PACK;

  logic          clk_b   = 1'b0;
  logic          rst     = 1'b1;
  logic          empty   = 1'b1;
  logic          flush   = 1'b0;
  logic          m_ready = 1'b0;
  logic [W-1:0]  dout_b  = '0;
  logic          ren_b;
  logic          m_valid;
  logic          m_last;
  logic [BW-1:0] m_data;

  typedef struct {
    logic [BW-1:0] data;
    logic          last;
  } beat_t;

  beat_t        exp_q[$];
  logic [W-1:0] fifo_q[$];
  logic [W-1:0] words_q[$];
  int           beat_no   = 0;
  int           checks    = 0;
  int           errors    = 0;
  int           ren_count = 0;
  bit           starve    = 1'b0;
  bit           took      = 1'b0;

  fifo_rd_packer #(
    .FIFO_WIDTH  (W),
    .PACK        (PACK),
    .FRAME_BEATS (FB)
  ) dut (
    .clk_b   (clk_b),
    .rst     (rst),
    .empty   (empty),
    .ren_b   (ren_b),
    .dout_b  (dout_b),
    .flush   (flush),
    .m_data  (m_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_last  (m_last)
  );

  always #5 clk_b = ~clk_b;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: every word accepted from the FIFO is appended in order;
  // each group of PACK words becomes one beat, every FB-th beat is last.
  task automatic model_word(input logic [W-1:0] w);
    beat_t b;
    words_q.push_back(w);
    if (words_q.size() == PACK) begin
      b.data = '0;
      for (int i = 0; i < PACK; i++) b.data[i*W +: W] = words_q[i];
      b.last = ((beat_no % FB) == FB - 1);
      beat_no++;
      exp_q.push_back(b);
      words_q.delete();
    end
  endtask

  task automatic model_flush();
    words_q.delete();
    exp_q.delete();
    beat_no = 0;
  endtask

  // One clock: FIFO pops on an accepted read, data returns after the next edge.
  task automatic step();
    logic [W-1:0] w;
    empty = (fifo_q.size() == 0) || starve;
    #1;
    took = ren_b;
    w    = '0;
    if (took) begin
      w = fifo_q.pop_front();
      ren_count++;
      model_word(w);
    end
    @(posedge clk_b);
    #1;
    dout_b = took ? w : W'($urandom);
    empty  = (fifo_q.size() == 0) || starve;
    @(negedge clk_b);
  endtask

  task automatic push_words(input int n);
    for (int i = 0; i < n; i++) fifo_q.push_back(W'($urandom));
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while ((fifo_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (fifo_q.size() != 0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: got %0d words, %0d beats left, required 0 and 0",
               name, fifo_q.size(), exp_q.size());
    end
  endtask

  // Scoreboard monitor: the head beat must match while shown, and is retired on transfer.
  initial begin
    forever begin
      @(negedge clk_b);
      #2;
      if (!rst && !flush && m_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL beat_unexpected: got data 0x%0h, required no beat", m_data);
        end else begin
          check("beat_data", m_data, exp_q[0].data);
          check("beat_last", m_last, exp_q[0].last);
          if (m_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    @(negedge clk_b);

    // Reset with a non-empty FIFO holding the pack-order pattern.
    rst     = 1'b1;
    m_ready = 1'b1;
    fifo_q.push_back(16'h1111);
    fifo_q.push_back(16'h2222);
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_ren", ren_b, 1'b0);
      check("rst_valid", m_valid, 1'b0);
      check("rst_data", m_data, '0);
      check("rst_last", m_last, 1'b0);
    end
    rst = 1'b0;
    #1;
    check("ren_after_rst", ren_b, 1'b1);

    // Latency: beat {0x2222,0x1111} valid for exactly one cycle, 3 cycles after first read.
    for (int k = 1; k <= 5; k++) begin
      step();
      check("lat_valid", m_valid, (k == 3));
    end
    check("pack_order_delivered", exp_q.size(), 0);

    // Backpressure: credit limits reads to 2*PACK, two beats queued and held.
    m_ready   = 1'b0;
    ren_count = 0;
    push_words(10);
    for (int i = 0; i < 20; i++) step();
    check("bp_ren_count", ren_count, 2 * PACK);
    check("bp_occ", dut.occ, 2 * PACK);
    check("bp_valid", m_valid, 1'b1);
    check("bp_queued", exp_q.size(), 2);
    m_ready = 1'b1;
    wait_drain("bp", 200);

    // Starve: odd word stays held as a partial pack until its partner arrives.
    push_words(3);
    for (int i = 0; i < 12; i++) step();
    check("starve_first_beat", exp_q.size(), 0);
    check("starve_no_partial", m_valid, 1'b0);
    for (int i = 0; i < 20; i++) step();
    check("starve_still_idle", m_valid, 1'b0);
    push_words(1);
    for (int i = 0; i < 8; i++) step();
    check("starve_second_beat", exp_q.size(), 0);

    // Frame: restart the frame count, 16 words -> last on beats 3 and 7.
    flush = 1'b1;
    model_flush();
    step();
    flush = 1'b0;
    push_words(16);
    wait_drain("frame", 200);

    // Flush with a word in flight and one beat queued.
    m_ready = 1'b0;
    push_words(6);
    for (int i = 0; i < 20; i++) begin
      step();
      if (took && m_valid) break;
    end
    check("pre_flush_rd_pend", dut.rd_pend, 1'b1);
    check("pre_flush_valid", m_valid, 1'b1);
    flush = 1'b1;
    model_flush();
    step();
    flush = 1'b0;
    check("flush_valid", m_valid, 1'b0);
    push_words(5);
    m_ready = 1'b1;
    wait_drain("post_flush", 200);

    // Random traffic with backpressure, starvation and occasional flushes.
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 2) == 0) push_words($urandom_range(1, 3));
      m_ready = ($urandom_range(0, 3) != 0);
      starve  = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 59) == 0) begin
        flush = 1'b1;
        model_flush();
      end
      step();
      flush = 1'b0;
    end
    starve  = 1'b0;
    m_ready = 1'b1;
    wait_drain("random", 2000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time limit so the bench always terminates.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
